// File: rtl/imm_decode_stage.sv
// RV instruction field/immediate decoder with a registered two-entry skid buffer.
// Decode happens on the input side; both buffer entries hold decoded results.
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;

    typedef logic [XLEN-1:0] xword_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t      dec;
    logic [2:0]  dec_fmt;
    logic        dec_illegal;
    logic [31:0] imm32;

    // Every recognised opcode ends in 2'b11, so the default arm also catches inst[1:0] != 2'b11.
    always_comb begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        unique case (in_inst[6:0])
            7'b0000011, 7'b0001111,
            7'b0010011, 7'b1100111: dec_fmt = FMT_I;
            7'b0100011:             dec_fmt = FMT_S;
            7'b1100011:             dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111:             dec_fmt = FMT_J;
            7'b0110011:             dec_fmt = FMT_R;
            7'b1110011:             dec_fmt = in_inst[14] ? FMT_Z : FMT_I;
            default:                dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        unique case (dec_fmt)
            FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U:   imm32 = {in_inst[31:12], 12'd0};
            FMT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.fmt     = dec_fmt;
        dec.illegal = dec_illegal;
        if (!dec_illegal) begin
            dec.rd  = (dec_fmt == FMT_S || dec_fmt == FMT_B) ? 5'd0 : in_inst[11:7];
            dec.rs1 = (dec_fmt == FMT_U || dec_fmt == FMT_J || dec_fmt == FMT_Z)
                      ? 5'd0 : in_inst[19:15];
            dec.rs2 = (dec_fmt == FMT_R || dec_fmt == FMT_S || dec_fmt == FMT_B)
                      ? in_inst[24:20] : 5'd0;
            dec.imm = (dec_fmt == FMT_Z) ? xword_t'(in_inst[19:15])
                                         : xword_t'($signed(imm32));
        end
    end

    entry_t o_q, o_d, k_q, k_d;
    logic   o_valid_q, o_valid_d, k_valid_q, k_valid_d;
    logic   accept, consume;

    assign accept  = in_valid & ~k_valid_q;
    assign consume = o_valid_q & out_ready;

    always_comb begin
        o_d       = o_q;
        k_d       = k_q;
        o_valid_d = o_valid_q;
        k_valid_d = k_valid_q;
        if (flush) begin
            o_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (consume && k_valid_q) begin
            // in_ready is low whenever K is full, so no accept competes here
            o_d       = k_q;
            k_valid_d = 1'b0;
        end else if (!o_valid_q || consume) begin
            o_valid_d = accept;
            if (accept) o_d = dec;
        end else if (accept) begin
            k_d       = dec;
            k_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_q       <= '0;
            k_q       <= '0;
            o_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
        end else begin
            o_q       <= o_d;
            k_q       <= k_d;
            o_valid_q <= o_valid_d;
            k_valid_q <= k_valid_d;
        end
    end

    assign in_ready    = ~k_valid_q;
    assign out_valid   = o_valid_q;
    assign out_pc      = o_q.pc;
    assign out_rd      = o_q.rd;
    assign out_rs1     = o_q.rs1;
    assign out_rs2     = o_q.rs2;
    assign out_imm     = o_q.imm;
    assign out_fmt     = o_q.fmt;
    assign out_illegal = o_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and compares both
// against a queue-based reference of the decode stage.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        r32, ov32, il32;
    logic [31:0] pc32, imm32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  fmt32;

    logic        r64, ov64, il64;
    logic [63:0] pc64, imm64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  fmt64;

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(ov32), .out_ready(out_ready), .out_pc(pc32),
        .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(il32)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(ov64), .out_ready(out_ready), .out_pc(pc64),
        .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(il64)
    );

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   zero_flag = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i, input logic [63:0] pc);
        exp_t   e;
        longint s;
        s     = longint'($signed(i));
        e.pc  = pc;
        e.ill = 1'b0;
        e.fmt = 3'd0;
        case (i[6:0])
            7'h03, 7'h0F, 7'h13, 7'h67: e.fmt = 3'd1;
            7'h23: e.fmt = 3'd2;
            7'h63: e.fmt = 3'd3;
            7'h37, 7'h17: e.fmt = 3'd4;
            7'h6F: e.fmt = 3'd5;
            7'h33: e.fmt = 3'd0;
            7'h73: e.fmt = i[14] ? 3'd6 : 3'd1;
            default: e.ill = 1'b1;
        endcase
        case (e.fmt)
            3'd1: e.imm = s >>> 20;
            3'd2: e.imm = ((s >>> 25) <<< 5) | longint'(i[11:7]);
            3'd3: e.imm = ((s >>> 31) <<< 12) | (longint'(i[7]) << 11)
                          | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
            3'd4: e.imm = s & ~64'hFFF;
            3'd5: e.imm = ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12)
                          | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
            3'd6: e.imm = longint'(i[19:15]);
            default: e.imm = 64'd0;
        endcase
        e.rd  = (e.fmt == 3'd2 || e.fmt == 3'd3) ? 5'd0 : i[11:7];
        e.rs1 = (e.fmt >= 3'd4) ? 5'd0 : i[19:15];
        e.rs2 = (e.fmt == 3'd0 || e.fmt == 3'd2 || e.fmt == 3'd3) ? i[24:20] : 5'd0;
        if (e.ill) begin
            e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = 64'd0;
        end
        return e;
    endfunction

    task automatic check_state();
        exp_t e;
        chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
        chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
        chk("in_ready32", 64'(r32), 64'(q.size() < 2));
        chk("in_ready64", 64'(r64), 64'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
        end else if (zero_flag) begin
            e = '{default: '0};
        end else begin
            return;
        end
        chk("pc32", 64'(pc32), 64'(e.pc[31:0]));
        chk("pc64", pc64, e.pc);
        chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
        chk("imm64", imm64, e.imm);
        chk("fmt32", 64'(fmt32), 64'(e.fmt));
        chk("fmt64", 64'(fmt64), 64'(e.fmt));
        chk("rd", 64'({rd32, rd64}), 64'({e.rd, e.rd}));
        chk("rs1", 64'({rs1_32, rs1_64}), 64'({e.rs1, e.rs1}));
        chk("rs2", 64'({rs2_32, rs2_64}), 64'({e.rs2, e.rs2}));
        chk("illegal", 64'({il32, il64}), 64'({e.ill, e.ill}));
    endtask

    // Called at a falling edge: drive inputs, advance the reference across the next
    // rising edge, then check the outputs at the following falling edge.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] inst, input logic [63:0] pc, input logic ordy);
        bit can_take;
        reset = rst; flush = fl; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
        can_take = (q.size() < 2);
        if (rst) begin
            q.delete();
            zero_flag = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && can_take) begin
                q.push_back(ref_dec(inst, pc));
                zero_flag = 1'b0;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    localparam int NOPS = 10;
    logic [6:0] ops [NOPS] = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h23,
                               7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int unsigned p;
        w = $urandom;
        p = $urandom_range(0, NOPS + 2);
        if (p < NOPS) w[6:0] = ops[p];
        else if (p == NOPS) w[6:0] = 7'h73;
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        cycle(1, 0, 0, 32'h0, 64'h0, 0);
        chk("rst_in_ready", 64'(r64), 64'd1);

        cycle(0, 0, 1, 32'hFFF0_0093, 64'h100, 1);
        chk("addi32_imm", 64'(imm32), 64'hFFFF_FFFF);
        chk("addi32_fields", 64'({ov32, fmt32, rd32, rs1_32, rs2_32}),
            64'({1'b1, 3'd1, 5'd1, 5'd0, 5'd0}));
        cycle(0, 0, 1, 32'hFE00_0EE3, 64'h104, 1);
        chk("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_fmt_rd", 64'({fmt64, rd64}), 64'({3'd3, 5'd0}));
        cycle(0, 0, 1, 32'h8000_02B7, 64'h108, 1);
        chk("lui_neg_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_fmt_rd", 64'({fmt64, rd64}), 64'({3'd4, 5'd5}));
        cycle(0, 0, 1, 32'h1234_52B7, 64'h10C, 1);
        chk("lui_pos_imm", imm64, 64'h0000_0000_1234_5000);
        cycle(0, 0, 1, 32'h300F_D0F3, 64'h110, 1);
        chk("csrrwi", 64'({fmt64, rd64, rs1_64}), 64'({3'd6, 5'd1, 5'd0}));
        chk("csrrwi_imm", imm64, 64'd31);
        cycle(0, 0, 1, 32'h0000_0000, 64'h114, 1);
        chk("illegal_zero", 64'({il64, fmt64}), 64'({1'b1, 3'd0}));
        chk("illegal_imm", imm64, 64'd0);
        cycle(0, 0, 0, 32'h0, 64'h0, 1);

        cycle(0, 0, 1, 32'h0000_0013, 64'h0, 0);
        cycle(0, 0, 1, 32'h0000_0013, 64'h4, 0);
        cycle(0, 0, 1, 32'h0000_0013, 64'h8, 0);
        chk("bp_in_ready_low", 64'(r64), 64'd0);
        chk("bp_pc_hold", pc64, 64'h0);
        cycle(0, 0, 1, 32'h0000_0013, 64'h8, 1);
        chk("bp_in_ready_back", 64'(r64), 64'd1);
        chk("bp_pc_second", pc64, 64'h4);
        cycle(0, 0, 1, 32'h0000_0013, 64'h8, 1);
        chk("bp_pc_third", pc64, 64'h8);
        cycle(0, 0, 0, 32'h0, 64'h0, 1);

        cycle(0, 0, 1, 32'h0010_0093, 64'h20, 0);
        cycle(0, 0, 1, 32'h0020_0093, 64'h24, 0);
        cycle(0, 1, 1, 32'h0030_0093, 64'h28, 0);
        chk("flush_state", 64'({ov64, r64, ov32, r32}), 64'({1'b0, 1'b1, 1'b0, 1'b1}));
        repeat (3) cycle(0, 0, 0, 32'h0, 64'h0, 1);

        cycle(0, 0, 1, 32'h0040_0093, 64'h30, 0);
        cycle(0, 0, 1, 32'h0050_0093, 64'h34, 0);
        cycle(1, 0, 1, 32'h0060_0093, 64'h38, 0);
        chk("rst_full_regs", 64'({ov64, r64, rd64, rs1_64, rs2_64, fmt64, il64}),
            64'({1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0}));
        chk("rst_full_data", pc64 | imm64, 64'd0);

        repeat (800) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) != 0), rand_inst(),
                  {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised successor to the combinational field/immediate extractor. It takes a full 32-bit RV instruction and derives the encoding format from the opcode itself. It extracts rd/rs1/rs2 and zeroes the ones the format does not use, and produces an XLEN-wide immediate, including the CSR zimm format. Results are held in a two-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush. The block sits between fetch and register-read.

## Interface
- XLEN, 32, immediate and PC width; legal values 32 or 64.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards both buffered entries and any same-cycle input.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; asserted when the skid entry is empty.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_inst, passed through unchanged.
- out_valid  out  1  output entry holds a decoded instruction.
- out_ready  in  1  downstream consumes the output this cycle.
- out_pc  out  XLEN  PC of the output entry.
- out_rd, out_rs1, out_rs2  out  5 each  register indices; unused fields are 0.
- out_imm  out  XLEN  immediate for the output entry.
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- out_illegal  out  1  opcode is not recognised, or inst[1:0]≠2'b11.

## Operation
- **Opcode to format (inst[6:0]):**
  - 0000011, 0001111, 0010011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → R.
  - 1110011 → Z if funct3[2]=1, otherwise I.
  - Anything else → illegal.
- **Illegal instructions:** out_illegal=1, fmt=R, imm=0, rd=rs1=rs2=0.
- **Immediates:** bit selection is standard RV32I. I/S/B/U/J results are sign-extended from their top bit to XLEN, so at XLEN=64 a U immediate is sign-extended from bit 31. Z is inst[19:15] zero-extended. R gives 0.
- **Field masking:**
  - rd is zeroed for S and B.
  - rs1 is zeroed for U, J and Z.
  - rs2 is kept only for R, S and B.
- **Decode placement:** decode is combinational on the input side, so both buffer entries store decoded results.
- **Buffer:** one output entry (O) and one skid entry (K).
  - in_ready = !K.valid, driven from a register.
  - Accept = in_valid & in_ready.
  - If O is empty, or O is being consumed while K is empty, the accepted data goes to O.
  - Otherwise the accepted data goes to K.
  - When O is consumed and K is valid, K moves to O.
- **Ordering:** outputs leave in strict arrival order. Nothing is dropped except by flush or reset.
- **Flush:** next cycle O.valid=0 and K.valid=0. The input in the flush cycle is not stored, and in_ready=1 the following cycle. Flush takes priority over accept and consume.

## Timing
- **Reset:** next edge forces out_valid=0, in_ready=1, out_pc=0, out_rd=out_rs1=out_rs2=0, out_imm=0, out_fmt=0 and out_illegal=0. Reset overrides flush and handshakes, including mid-transfer.
- **Latency:** exactly 1 cycle from accept to out_valid when O is empty or draining.
- **Throughput:** 1 instruction per cycle sustained with out_ready=1.
- **Output handshake:** while out_valid=1 and out_ready=0, every out_* signal is held stable.
- **Full buffer:** O and K both valid gives in_ready=0 in the next cycle. in_ready returns to 1 in the cycle after the first consume.
- **Simultaneous accept and consume:**
  - K empty: new data lands in O, no bubble.
  - K full: in_ready is already 0, so no accept can occur.
- **Paths:** no combinational path from in_* to out_*, or from out_ready to in_ready.

## Test plan
- **ADDI, XLEN=32:** accept 0xFFF00093 with out_ready=1 → next cycle out_valid=1, fmt=1, rd=1, rs1=0, rs2=0, imm=0xFFFFFFFF.
- **BEQ and LUI, XLEN=64:**
  - BEQ 0xFE000EE3 → fmt=3, rd=0, imm=0xFFFFFFFFFFFFFFFC.
  - LUI 0x800002B7 → fmt=4, rd=5, imm=0xFFFFFFFF80000000.
  - LUI 0x123452B7 → imm=0x0000000012345000.
- **CSRRWI and illegal:**
  - CSRRWI 0x300FD0F3 → fmt=6, rd=1, rs1=0, imm=31.
  - 0x00000000 → out_illegal=1, fmt=0, imm=0.
- **Backpressure:**
  - Hold out_ready=0 and offer PCs 0x0, 0x4, 0x8 back-to-back → first two accepted, in_ready=0 while the third waits, and out_pc holds 0x0 steady.
  - Then raise out_ready → outputs 0x0, 0x4, 0x8 in order, with in_ready=1 one cycle after the first consume.
- **Flush:** with both entries full, pulse flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed and offered instructions never appear.
- **Reset:** assert reset while both entries are full and out_ready=0 → next cycle all outputs are at their reset values and in_ready=1.
